// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/exception controller: FSM state
// encodings, reset level and stall-vector bit positions.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PEND  = 2'd1,
      FLUSH = 2'd2
   } pipe_state_e;

   localparam logic RESET_ENABLE = 1'b1;

   localparam int STALL_PC     = 0;
   localparam int STALL_IF_ID  = 1;
   localparam int STALL_ID_EX  = 2;
   localparam int STALL_EX_MEM = 3;
   localparam int STALL_MEM_WB = 4;

endpackage

// File: rtl/pipe_ctrl_stall_mask_gen.sv
// Priority encoder from per-stage stall requests to a thermometer hold mask:
// the deepest requesting stage holds itself and every register upstream of it.
module pipe_ctrl_stall_mask_gen
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE = 6
) (
   input  logic [NSTAGE-2:0] stall_req,
   output logic [NSTAGE-1:0] mask
);

   logic acc;

   always_comb begin
      mask = '0;
      acc  = 1'b0;
      for (int i = NSTAGE - 1; i >= 1; i--) begin
         acc     = acc | stall_req[i-1];
         mask[i] = acc;
      end
      mask[STALL_PC] = acc;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: stall vector, flush sequencing and
// stall watchdog. Define PIPE_CTRL_PERF_EN to add stall/flush perf counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE    = 6,
   parameter int AW        = 32,
   parameter int STALL_MAX = 255,
   parameter int CW        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-2:0] stall_req,
   input  logic              flush_req,
   input  logic [AW-1:0]     flush_pc,
   output logic [NSTAGE-1:0] stall,
   output logic              flush,
   output logic [AW-1:0]     new_pc,
   output logic              stall_timeout
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_stall_cyc,
   output logic [31:0]       perf_flush_cnt
`endif
);

   pipe_state_e       state;
   logic [NSTAGE-1:0] req_mask;
   logic [CW-1:0]     run_cnt;
   logic [CW-1:0]     run_inc;
   logic [AW-1:0]     cap_pc;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      if (c >= CW'(STALL_MAX))
         sat_inc = c;
      else
         sat_inc = c + 1'b1;
   endfunction

   pipe_ctrl_stall_mask_gen #(
      .NSTAGE (NSTAGE)
   ) u_mask (
      .stall_req (stall_req),
      .mask      (req_mask)
   );

   // A pending flush freezes everything; the flush cycle releases all holds
   // because the requesting stages are being cleared anyway.
   always_comb begin
      stall = '0;
      case (state)
         RUN:     stall = flush_req ? '1 : req_mask;
         PEND:    stall = '1;
         FLUSH:   stall = '0;
         default: stall = '0;
      endcase
   end

   always_comb run_inc = sat_inc(run_cnt);

   always_ff @(posedge clk) begin
      if (rst == RESET_ENABLE) begin
         state         <= RUN;
         flush         <= 1'b0;
         new_pc        <= '0;
         stall_timeout <= 1'b0;
         run_cnt       <= '0;
      end else begin
         case (state)
            RUN: begin
               flush <= 1'b0;
               if (flush_req) begin
                  state   <= PEND;
                  run_cnt <= '0;
               end else if (|stall_req) begin
                  run_cnt       <= run_inc;
                  stall_timeout <= stall_timeout | (run_inc == CW'(STALL_MAX));
               end else begin
                  run_cnt <= '0;
               end
            end
            PEND: begin
               state  <= FLUSH;
               flush  <= 1'b1;
               new_pc <= cap_pc;
            end
            FLUSH: begin
               state <= RUN;
               flush <= 1'b0;
            end
            default: begin
               state <= RUN;
               flush <= 1'b0;
            end
         endcase
      end
   end

   // Redirect target is data: captured on request acceptance, no reset needed.
   always_ff @(posedge clk) begin
      if (state == RUN && flush_req)
         cap_pc <= flush_pc;
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst == RESET_ENABLE) begin
         perf_stall_cyc <= '0;
         perf_flush_cnt <= '0;
      end else begin
         perf_stall_cyc <= perf_stall_cyc + {31'd0, |stall};
         perf_flush_cnt <= perf_flush_cnt + {31'd0, state == FLUSH};
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with a cycle-level reference model and
// directed literal checks; perf counters are checked when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

   localparam int NS   = 6;
   localparam int AW   = 32;
   localparam int SMAX = 4;

   logic          clk;
   logic          rst;
   logic [NS-2:0] stall_req;
   logic          flush_req;
   logic [AW-1:0] flush_pc;
   logic [NS-1:0] stall;
   logic          flush;
   logic [AW-1:0] new_pc;
   logic          stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]   perf_stall_cyc;
   logic [31:0]   perf_flush_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   pipe_ctrl #(
      .NSTAGE    (NS),
      .AW        (AW),
      .STALL_MAX (SMAX),
      .CW        (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_req     (stall_req),
      .flush_req     (flush_req),
      .flush_pc      (flush_pc),
      .stall         (stall),
      .flush         (flush),
      .new_pc        (new_pc),
      .stall_timeout (stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cyc (perf_stall_cyc),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Highest requesting stage k (1-based) holds registers 0..k.
   function automatic logic [NS-1:0] therm(input logic [NS-2:0] req);
      int k;
      k = 0;
      for (int j = 0; j < NS - 1; j++)
         if (req[j]) k = j + 1;
      if (k == 0) return '0;
      return NS'((64'd1 << (k + 1)) - 1);
   endfunction

   // Reference model: m_left counts the cycles remaining in a flush sequence
   // (2 = request accepted last edge, 1 = redirect cycle, 0 = normal running).
   int            m_left = 0;
   logic [AW-1:0] m_pc = '0;
   logic [AW-1:0] m_newpc = '0;
   int            m_run = 0;
   bit            m_to = 0;
   logic [31:0]   m_pstall = '0;
   logic [31:0]   m_pflush = '0;

   always @(negedge clk) begin : model_cmp
      logic [NS-1:0] exp_stall;
      if (m_left == 0)      exp_stall = flush_req ? '1 : therm(stall_req);
      else if (m_left == 2) exp_stall = '1;
      else                  exp_stall = '0;

      if (chk_en) begin
         check("m_stall", 64'(stall), 64'(exp_stall));
         check("m_flush", 64'(flush), 64'(m_left == 1));
         check("m_new_pc", 64'(new_pc), 64'(m_newpc));
         check("m_timeout", 64'(stall_timeout), 64'(m_to));
`ifdef PIPE_CTRL_PERF_EN
         check("m_perf_stall", 64'(perf_stall_cyc), 64'(m_pstall));
         check("m_perf_flush", 64'(perf_flush_cnt), 64'(m_pflush));
`endif
      end

      if (rst) begin
         m_left = 0; m_newpc = '0; m_run = 0; m_to = 0;
         m_pstall = '0; m_pflush = '0;
      end else begin
         if (exp_stall != '0) m_pstall = m_pstall + 1;
         if (m_left == 1)     m_pflush = m_pflush + 1;
         if (m_left == 0) begin
            if (flush_req) begin
               m_left = 2; m_pc = flush_pc; m_run = 0;
            end else if (stall_req != '0) begin
               m_run = (m_run + 1 > SMAX) ? SMAX : m_run + 1;
               if (m_run == SMAX) m_to = 1;
            end else begin
               m_run = 0;
            end
         end else if (m_left == 2) begin
            m_left = 1; m_newpc = m_pc;
         end else begin
            m_left = 0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1; stall_req = '0; flush_req = 1'b0; flush_pc = '0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_stall", 64'(stall), 64'h0);
      check("rst_flush", 64'(flush), 64'h0);
      check("rst_new_pc", 64'(new_pc), 64'h0);
      check("rst_timeout", 64'(stall_timeout), 64'h0);
      cyc();
      rst = 1'b0;

      // Thermometer mask, runs kept below the watchdog limit
      stall_req = 5'b00010; @(negedge clk); check("therm_id", 64'(stall), 64'b000111); cyc();
      stall_req = 5'b00110; @(negedge clk); check("therm_id_ex", 64'(stall), 64'b001111); cyc();
      stall_req = 5'b10000; @(negedge clk); check("therm_top", 64'(stall), 64'b111111); cyc();
      stall_req = 5'b00000; @(negedge clk); check("therm_none", 64'(stall), 64'h0); cyc();
      stall_req = 5'b00001; @(negedge clk); check("therm_if", 64'(stall), 64'b000011); cyc();
      stall_req = 5'b00000; cyc();

      // Single flush sequence with a concurrent ID stall
      stall_req = 5'b00010; flush_req = 1'b1; flush_pc = 32'h0000_0040;
      @(negedge clk); check("fl_n_stall", 64'(stall), 64'h3f); check("fl_n_flush", 64'(flush), 64'h0); cyc();
      flush_req = 1'b0; flush_pc = 32'h0000_dead;
      @(negedge clk); check("fl_n1_stall", 64'(stall), 64'h3f); check("fl_n1_flush", 64'(flush), 64'h0); cyc();
      @(negedge clk); check("fl_n2_stall", 64'(stall), 64'h0); check("fl_n2_flush", 64'(flush), 64'h1);
      check("fl_n2_pc", 64'(new_pc), 64'h40); cyc();
      @(negedge clk); check("fl_n3_flush", 64'(flush), 64'h0); check("fl_n3_pc", 64'(new_pc), 64'h40);
      check("fl_n3_stall", 64'(stall), 64'b000111); cyc();
      stall_req = 5'b00000; cyc();

      // Held flush request: second sequence accepted in N+3
      flush_req = 1'b1; flush_pc = 32'h0000_0080; cyc();
      flush_pc = 32'h0000_0084; cyc();
      flush_pc = 32'h0000_0088;
      @(negedge clk); check("hold_n2_flush", 64'(flush), 64'h1); check("hold_n2_pc", 64'(new_pc), 64'h80); cyc();
      flush_pc = 32'h0000_00c0;
      @(negedge clk); check("hold_n3_flush", 64'(flush), 64'h0); check("hold_n3_stall", 64'(stall), 64'h3f); cyc();
      flush_req = 1'b0; cyc();
      @(negedge clk); check("hold_n5_flush", 64'(flush), 64'h1); check("hold_n5_pc", 64'(new_pc), 64'hc0); cyc();
      @(negedge clk); check("hold_n6_flush", 64'(flush), 64'h0); cyc();

      // Watchdog: four consecutive stalled cycles
      stall_req = 5'b00100;
      for (int i = 0; i < SMAX; i++) begin
         @(negedge clk); check("wd_stall", 64'(stall), 64'b001111); check("wd_before", 64'(stall_timeout), 64'h0);
         cyc();
      end
      stall_req = 5'b00000;
      @(negedge clk); check("wd_set", 64'(stall_timeout), 64'h1); cyc();
      cyc();
      @(negedge clk); check("wd_sticky", 64'(stall_timeout), 64'h1); cyc();

      // Reset while the flush is pending
      flush_req = 1'b1; flush_pc = 32'h0000_0100; cyc();
      rst = 1'b1; flush_req = 1'b0; stall_req = 5'b00010;
      @(negedge clk); check("rp_pend_stall", 64'(stall), 64'h3f); cyc();
      rst = 1'b0;
      @(negedge clk); check("rp_stall", 64'(stall), 64'b000111); check("rp_flush", 64'(flush), 64'h0);
      check("rp_pc", 64'(new_pc), 64'h0); check("rp_timeout", 64'(stall_timeout), 64'h0); cyc();
      stall_req = 5'b00000;
      @(negedge clk); check("rp_flush2", 64'(flush), 64'h0); cyc();

`ifdef PIPE_CTRL_PERF_EN
      rst = 1'b1; cyc();
      rst = 1'b0;
      stall_req = 5'b00001; cyc(); cyc(); cyc();
      stall_req = 5'b00000; flush_req = 1'b1; flush_pc = 32'h0000_0200; cyc();
      flush_req = 1'b0; cyc(); cyc();
      @(negedge clk); check("perf_stall", 64'(perf_stall_cyc), 64'd5); check("perf_flush", 64'(perf_flush_cnt), 64'd1);
      cyc();
`endif

      cyc(); cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline hazard/exception controller for the OpenMIPS core; successor to the fixed two-source stall controller.
- Accepts per-stage stall requests from any pipeline stage and a flush (exception) request. Produces the per-register stall vector, a one-cycle flush pulse and the redirect PC.
- Adds a flush sequencing FSM, a consecutive-stall watchdog and optional performance counters.
- Sits beside the pipeline registers; its stall/flush outputs fan out to pc_reg and every inter-stage register.

Parameters:
- NSTAGE, 6, width of stall vector. Bit 0 = PC, bit k = k-th pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB, ...).
- AW, 32, address width of flush_pc/new_pc.
- STALL_MAX, 255, number of consecutive stalled cycles that raises stall_timeout (must be ≥1).
- CW, 8, width of the internal stall-run counter; must satisfy 2^CW > STALL_MAX.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_req  in  NSTAGE-1  bit j (j=0..NSTAGE-2) = stall request from stage j+1 (1=IF, 2=ID, 3=EX, ...).
- flush_req  in  1  exception/flush request, level, sampled each cycle.
- flush_pc  in  AW  handler/redirect address, valid with flush_req.
- stall  out  NSTAGE  1 = hold that register.
- flush  out  1  one-cycle pipeline clear pulse.
- new_pc  out  AW  redirect target, valid while flush=1.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset: state=RUN, stall=0, flush=0, new_pc=0, stall_timeout=0, run counter=0.
- FSM states:
  - RUN to PEND when flush_req=1.
  - PEND to FLUSH unconditionally.
  - FLUSH to RUN unconditionally.
- Stall vector (combinational from state and inputs):
  - RUN, flush_req=0: let k = highest index with stall_req bit j=k-1 set. Then stall = (1<<(k+1))-1, i.e. bits [k:0]. No request gives stall=0. Lower-index requests are subsumed.
  - RUN with flush_req=1, and all of PEND: stall = all ones. This freezes the faulting instruction and blocks further commits.
  - FLUSH: stall = 0. stall_req is ignored because it comes from flushed stages.
- Flush timing:
  - flush_pc is captured on the RUN→PEND edge (cycle N).
  - flush=1 and new_pc=captured value in cycle N+2 (FLUSH state), registered outputs.
  - flush=0 in every other state. new_pc holds its last value when flush=0.
- flush_req while in PEND or FLUSH is ignored; no queueing. A level still high in the cycle after FLUSH starts a new sequence.
- Stall-run counter:
  - In RUN, increments (saturating at STALL_MAX) each cycle stall≠0 due to stall_req.
  - Clears on any RUN cycle with stall=0, and on entering PEND.
  - When counter reaches STALL_MAX, stall_timeout sets at the next edge and stays set until rst.
- Reset mid-sequence (PEND/FLUSH): return to RUN next edge, no flush pulse emitted.
- Latency: stall is 0-cycle combinational; flush is 2 cycles after the request edge.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cyc[31:0] and perf_flush_cnt[31:0], both reset to 0.
  - perf_stall_cyc counts every cycle stall≠0 (any state); perf_flush_cnt counts FLUSH-state cycles.
  - Both are 32-bit counters that wrap modulo 2^32.
- When undefined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package/include (define.v): FSM state encodings (RUN=2'd0, PEND=2'd1, FLUSH=2'd2), ResetEnable, stall-bit index constants for PC/IF_ID/ID_EX/EX_MEM/MEM_WB.
- One natural sub-module: stall_mask_gen, a combinational priority encoder from stall_req to a thermometer mask, parametrised by NSTAGE.

Test Plan:
- stall_req=5'b00010 (ID) in RUN → stall=6'b000111. stall_req=5'b00110 → 6'b001111. stall_req=5'b10000 → 6'b111111.
- flush_req=1, flush_pc=32'h0000_0040 at cycle N with stall_req=5'b00010 → stall=6'b111111 in N and N+1. In N+2: flush=1, new_pc=0x40, stall=0. In N+3: flush=0.
- flush_req held high for 3 cycles → exactly one flush pulse per PEND→FLUSH pass; the second sequence starts in cycle N+3.
- STALL_MAX=4, stall_req=5'b00100 held 4 cycles → stall_timeout=1 after the 4th stalled edge. Then release and rst=0 → stays 1. rst=1 → clears.
- rst asserted in PEND → next cycle RUN, flush never 1, stall follows stall_req.
- With PIPE_CTRL_PERF_EN: 3 stalled cycles plus 1 flush sequence → perf_stall_cyc=5 (3 + PEND cycle + flush-request cycle), perf_flush_cnt=1.
